// File: rtl/regfile_arbiter.sv
// Two-client round-robin front end for the 32x32 register file.
// After reset it clears registers 1..31, then grants one whole read/write transaction per cycle.
module regfile_arbiter #(
  parameter logic INIT_ENABLE = 1'b1
) (
  input  logic        Clk,
  input  logic        ResetN,
  // client A
  input  logic        ReqA,
  input  logic        WeA,
  input  logic [4:0]  RAddr1A,
  input  logic [4:0]  RAddr2A,
  input  logic [4:0]  WAddrA,
  input  logic [31:0] WDataA,
  output logic        GntA,
  output logic        RValidA,
  output logic [31:0] RData1A,
  output logic [31:0] RData2A,
  // client B
  input  logic        ReqB,
  input  logic        WeB,
  input  logic [4:0]  RAddr1B,
  input  logic [4:0]  RAddr2B,
  input  logic [4:0]  WAddrB,
  input  logic [31:0] WDataB,
  output logic        GntB,
  output logic        RValidB,
  output logic [31:0] RData1B,
  output logic [31:0] RData2B,
  // register file side
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  output logic        InitDone
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam state_e RESET_STATE = (INIT_ENABLE != 1'b0) ? ST_INIT : ST_RUN;
  localparam logic   RESET_DONE  = (INIT_ENABLE != 1'b0) ? 1'b0 : 1'b1;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        init_done_q, init_done_d;
  logic        ptr_q, ptr_d;          // 0: A has priority, 1: B has priority
  logic        run_s;
  logic        gnt_a_s, gnt_b_s;
  logic        rvalid_a_q, rvalid_b_q;
  logic [31:0] rdata1_a_q, rdata2_a_q;
  logic [31:0] rdata1_b_q, rdata2_b_q;
  logic [4:0]  rreg1_s, rreg2_s, wreg_s;
  logic [31:0] wdata_s;
  logic        regwrite_s;

  // Sequencer next state: walk the clear counter 1..31, then stay in RUN.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == 5'd31) begin
          state_d     = ST_RUN;
          cnt_d       = 5'd1;
          init_done_d = 1'b1;
        end else begin
          cnt_d       = cnt_q + 5'd1;
        end
      end
      ST_RUN: begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
      default: begin
        state_d     = RESET_STATE;
        cnt_d       = 5'd1;
        init_done_d = RESET_DONE;
      end
    endcase
  end

  // Sequencer state, clear counter and InitDone flag.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= RESET_STATE;
      cnt_q       <= 5'd1;
      init_done_q <= RESET_DONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Round-robin grant; gated by ResetN so a transaction in flight at reset is dropped.
  always_comb begin
    run_s   = (state_q == ST_RUN) && ResetN;
    gnt_a_s = run_s && ReqA && (!ReqB || !ptr_q);
    gnt_b_s = run_s && ReqB && (!ReqA ||  ptr_q);
    if (gnt_a_s) begin
      ptr_d = 1'b1;
    end else if (gnt_b_s) begin
      ptr_d = 1'b0;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Register-file port mux: clear writes in INIT, granted client in RUN, idle otherwise.
  always_comb begin
    rreg1_s    = 5'd0;
    rreg2_s    = 5'd0;
    wreg_s     = 5'd0;
    wdata_s    = 32'd0;
    regwrite_s = 1'b0;
    if (state_q == ST_INIT) begin
      wreg_s     = cnt_q;
      regwrite_s = ResetN;
    end else if (gnt_a_s) begin
      rreg1_s    = RAddr1A;
      rreg2_s    = RAddr2A;
      wreg_s     = WAddrA;
      wdata_s    = WDataA;
      regwrite_s = WeA;
    end else if (gnt_b_s) begin
      rreg1_s    = RAddr1B;
      rreg2_s    = RAddr2B;
      wreg_s     = WAddrB;
      wdata_s    = WDataB;
      regwrite_s = WeB;
    end else begin
      rreg1_s    = 5'd0;
      rreg2_s    = 5'd0;
      wreg_s     = 5'd0;
      wdata_s    = 32'd0;
      regwrite_s = 1'b0;
    end
  end

  // Client A read capture; sampled at the same edge the regfile write lands, so it sees the old value.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      rvalid_a_q <= 1'b0;
      rdata1_a_q <= 32'd0;
      rdata2_a_q <= 32'd0;
    end else begin
      rvalid_a_q <= gnt_a_s;
      if (gnt_a_s) begin
        rdata1_a_q <= ReadData1;
        rdata2_a_q <= ReadData2;
      end
    end
  end

  // Client B read capture.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      rvalid_b_q <= 1'b0;
      rdata1_b_q <= 32'd0;
      rdata2_b_q <= 32'd0;
    end else begin
      rvalid_b_q <= gnt_b_s;
      if (gnt_b_s) begin
        rdata1_b_q <= ReadData1;
        rdata2_b_q <= ReadData2;
      end
    end
  end

  assign GntA          = gnt_a_s;
  assign GntB          = gnt_b_s;
  assign RValidA       = rvalid_a_q;
  assign RData1A       = rdata1_a_q;
  assign RData2A       = rdata2_a_q;
  assign RValidB       = rvalid_b_q;
  assign RData1B       = rdata1_b_q;
  assign RData2B       = rdata2_b_q;
  assign ReadRegister1 = rreg1_s;
  assign ReadRegister2 = rreg2_s;
  assign WriteRegister = wreg_s;
  assign WriteData     = wdata_s;
  assign RegWrite      = regwrite_s;
  assign InitDone      = init_done_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized bench for regfile_arbiter: a behavioural regfile plus a transaction-level
// reference model (memory array, turn flag, per-client read results) checked every cycle.
module tb_regfile_arbiter;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic        req [2];
  logic        we  [2];
  logic [4:0]  r1  [2];
  logic [4:0]  r2  [2];
  logic [4:0]  wa  [2];
  logic [31:0] wd  [2];
  logic        GntA, GntB, RValidA, RValidB, InitDone, RegWrite;
  logic [31:0] RData1A, RData2A, RData1B, RData2B, WriteData, ReadData1, ReadData2;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;

  always #5 Clk = ~Clk;

  regfile_arbiter #(.INIT_ENABLE(1'b1)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .ReqA(req[0]), .WeA(we[0]), .RAddr1A(r1[0]), .RAddr2A(r2[0]), .WAddrA(wa[0]), .WDataA(wd[0]),
    .GntA(GntA), .RValidA(RValidA), .RData1A(RData1A), .RData2A(RData2A),
    .ReqB(req[1]), .WeB(we[1]), .RAddr1B(r1[1]), .RAddr2B(r2[1]), .WAddrB(wa[1]), .WDataB(wd[1]),
    .GntB(GntB), .RValidB(RValidB), .RData1B(RData1B), .RData2B(RData2B),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .RegWrite(RegWrite), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .InitDone(InitDone)
  );

  // Behavioural 32x32 register file; scramble fills it with junk so the clear sequence matters.
  logic [31:0] rf [32];
  logic        scramble = 1'b0;
  always @(posedge Clk) begin
    if (scramble) begin
      for (int i = 0; i < 32; i++) rf[i] <= $urandom;
    end else if (RegWrite && WriteRegister != 5'd0) begin
      rf[WriteRegister] <= WriteData;
    end
  end
  assign ReadData1 = (ReadRegister1 == 5'd0) ? 32'd0 : rf[ReadRegister1];
  assign ReadData2 = (ReadRegister2 == 5'd0) ? 32'd0 : rf[ReadRegister2];

  // Reference model state
  logic [31:0] m_mem [32];
  int          m_turn;          // client that wins a tie
  int          m_init_left;     // clear cycles still to go
  logic [31:0] m_rd1 [2];
  logic [31:0] m_rd2 [2];
  logic        m_rv  [2];
  logic        just_granted [2];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
    m_turn      = 0;
    m_init_left = 31;
    for (int c = 0; c < 2; c++) begin
      m_rd1[c] = 32'd0; m_rd2[c] = 32'd0; m_rv[c] = 1'b0; just_granted[c] = 1'b0;
    end
  endtask

  task automatic set_req(input int c, input logic rq, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [4:0] x1, input logic [4:0] x2);
    req[c] = rq; we[c] = w; wa[c] = a; wd[c] = d; r1[c] = x1; r2[c] = x2;
  endtask

  // One cycle: inputs are already driven after a falling edge; check, then advance the model.
  task automatic tick();
    int g;
    #1;
    g = -1;
    if (!ResetN) begin
      check_eq("rst_regwrite", {31'd0, RegWrite}, 32'd0);
      check_eq("rst_gnt", {30'd0, GntB, GntA}, 32'd0);
      check_eq("rst_initdone", {31'd0, InitDone}, 32'd0);
      check_eq("rst_rvalid", {30'd0, RValidB, RValidA}, 32'd0);
      check_eq("rst_rdata", RData1A | RData2A | RData1B | RData2B, 32'd0);
    end else begin
      if (m_init_left > 0) begin
        check_eq("init_gnt", {30'd0, GntB, GntA}, 32'd0);
        check_eq("init_regwrite", {31'd0, RegWrite}, 32'd1);
        check_eq("init_waddr", {27'd0, WriteRegister}, 32'(32 - m_init_left));
        check_eq("init_wdata", WriteData, 32'd0);
        check_eq("init_raddr", {22'd0, ReadRegister2, ReadRegister1}, 32'd0);
      end else begin
        if (req[0] && req[1]) g = m_turn;
        else if (req[0])      g = 0;
        else if (req[1])      g = 1;
        check_eq("gnt_a", {31'd0, GntA}, {31'd0, g == 0});
        check_eq("gnt_b", {31'd0, GntB}, {31'd0, g == 1});
        if (g >= 0) begin
          check_eq("mux_raddr", {22'd0, ReadRegister2, ReadRegister1}, {22'd0, r2[g], r1[g]});
          check_eq("mux_waddr", {27'd0, WriteRegister}, {27'd0, wa[g]});
          check_eq("mux_wdata", WriteData, wd[g]);
          check_eq("mux_we", {31'd0, RegWrite}, {31'd0, we[g]});
        end else begin
          check_eq("idle_ports", {17'd0, RegWrite, WriteRegister, ReadRegister2, ReadRegister1}, 32'd0);
          check_eq("idle_wdata", WriteData, 32'd0);
        end
      end
      check_eq("initdone", {31'd0, InitDone}, {31'd0, m_init_left == 0});
      check_eq("rvalid_a", {31'd0, RValidA}, {31'd0, m_rv[0]});
      check_eq("rvalid_b", {31'd0, RValidB}, {31'd0, m_rv[1]});
      check_eq("rdata1_a", RData1A, m_rd1[0]);
      check_eq("rdata2_a", RData2A, m_rd2[0]);
      check_eq("rdata1_b", RData1B, m_rd1[1]);
      check_eq("rdata2_b", RData2B, m_rd2[1]);
    end
    @(posedge Clk);
    if (!ResetN) begin
      model_reset();
    end else if (m_init_left > 0) begin
      m_init_left--;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_rv[c] = (g == c);
        just_granted[c] = (g == c);
      end
      if (g >= 0) begin
        m_rd1[g] = m_mem[r1[g]];
        m_rd2[g] = m_mem[r2[g]];
        if (we[g] && wa[g] != 5'd0) m_mem[wa[g]] = wd[g];
        m_turn = 1 - g;
      end
    end
    @(negedge Clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    set_req(0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    set_req(1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    repeat (n) tick();
  endtask

  initial begin
    model_reset();
    idle(0);
    scramble = 1'b1;
    @(negedge Clk);
    tick(); tick();
    scramble = 1'b0;
    ResetN = 1'b1;
    idle(32);                                       // full clear plus one idle RUN cycle

    // Directed transactions
    set_req(0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31);          tick();
    set_req(0, 1'b1, 1'b1, 5'd2, 32'd42, 5'd2, 5'd3);          tick();
    set_req(0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd2, 5'd2);           tick();
    idle(1);
    set_req(0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd2, 5'd3);
    set_req(1, 1'b1, 1'b1, 5'd3, 32'd15, 5'd0, 5'd0);
    repeat (4) tick();
    idle(1);
    set_req(0, 1'b1, 1'b0, 5'd1, 32'hDEADBEEF, 5'd1, 5'd1);    tick();
    set_req(0, 1'b1, 1'b1, 5'd0, 32'd42, 5'd1, 5'd0);          tick();
    set_req(0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);           tick();
    idle(1);

    // Random traffic; a request not yet granted keeps its fields
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!req[c] || just_granted[c]) begin
          set_req(c, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
      end
      tick();
    end

    // Reset pulse mid-clear at cnt=10
    idle(1);
    ResetN = 1'b0; tick();
    ResetN = 1'b1; idle(9);
    ResetN = 1'b0; tick();
    ResetN = 1'b1; idle(32);
    set_req(0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd31); tick();

    // Reset while A is waiting behind B
    if (m_turn == 0) begin
      set_req(0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
      set_req(1, 1'b1, 1'b1, 5'd4, 32'd7, 5'd4, 5'd4);
      tick();
    end
    set_req(0, 1'b1, 1'b1, 5'd6, 32'h0BAD_F00D, 5'd6, 5'd4);
    set_req(1, 1'b1, 1'b1, 5'd4, 32'd77, 5'd4, 5'd6);
    tick();
    set_req(1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    ResetN = 1'b0; tick(); tick();
    ResetN = 1'b1;
    repeat (33) tick();                               // A held through the new clear, then served
    set_req(0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd6, 5'd4); tick();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
